irq_trap_ctrl: RTL and testbench

// Machine-mode interrupt/trap sequencer between external IRQ lines, the pipeline and the CSR file.

---
 rtl/irq_trap_ctrl_if.sv | 32 +++
 rtl/irq_trap_ctrl.sv | 154 +++++++++++++++
 tb/tb_irq_trap_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/irq_trap_ctrl_if.sv
// Pipeline/CSR-side signal bundle for irq_trap_ctrl.
// slave modport: the trap controller. master modport: the pipeline/CSR side.
interface irq_trap_ctrl_if #(
    parameter int CAUSE_W = 4
) ();
    logic               mie_i;
    logic [31:0]        tvec_i;
    logic [31:0]        epc_i;
    logic [31:0]        pc_i;
    logic               mret_i;
    logic               halt_req_o;
    logic               halt_ack_i;
    logic               save_epc_o;
    logic [31:0]        epc_pc_o;
    logic               mret_o;
    logic               pc_set_o;
    logic [31:0]        pc_target_o;
    logic [CAUSE_W-1:0] cause_o;
    logic               in_trap_o;

    modport slave (
        input  mie_i, tvec_i, epc_i, pc_i, mret_i, halt_ack_i,
        output halt_req_o, save_epc_o, epc_pc_o, mret_o, pc_set_o,
               pc_target_o, cause_o, in_trap_o
    );

    modport master (
        output mie_i, tvec_i, epc_i, pc_i, mret_i, halt_ack_i,
        input  halt_req_o, save_epc_o, epc_pc_o, mret_o, pc_set_o,
               pc_target_o, cause_o, in_trap_o
    );
endinterface

// File: rtl/irq_trap_ctrl.sv
// Machine-mode interrupt/trap sequencer: latches IRQ rising edges, picks the
// lowest pending index, halts the pipeline, strobes CSR save/mret and
// redirects the PC.
// Optional feature: define IRQ_VECTORED_EN for vectored trap targets
// (base + cause*4); otherwise every trap goes to the aligned mtvec base.
module irq_trap_ctrl #(
    parameter int N_IRQ   = 8,
    parameter int CAUSE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_i,
    irq_trap_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        SAVE = 3'd2,
        TRAP = 3'd3,
        RET  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [N_IRQ-1:0]   irq_q, irq_d;
    logic               armed_q, armed_d;
    logic [N_IRQ-1:0]   pending_q, pending_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic [31:0]        epc_pc_q, epc_pc_d;
    logic [31:0]        pc_target_q, pc_target_d;
    logic               halt_req_q, halt_req_d;
    logic               save_epc_q, save_epc_d;
    logic               mret_q, mret_d;
    logic               pc_set_q, pc_set_d;
    logic               in_trap_q, in_trap_d;

    logic [CAUSE_W-1:0] sel;
    logic               sel_found;
    logic [N_IRQ-1:0]   clr_mask;
    logic [N_IRQ-1:0]   irq_rise;
    logic [31:0]        vector;

    // Edge detection, lowest-index selection and pending set/clear.
    // armed_q blocks edge detection on the first cycle after reset so a line
    // held high across reset does not look like a fresh rising edge.
    always_comb begin
        irq_d     = irq_i;
        armed_d   = 1'b1;
        irq_rise  = irq_i & ~irq_q & {N_IRQ{armed_q}};
        sel       = '0;
        sel_found = 1'b0;
        clr_mask  = '0;
        for (int unsigned k = 0; k < N_IRQ; k++) begin
            if (pending_q[k] && !sel_found) begin
                sel       = CAUSE_W'(k);
                sel_found = 1'b1;
            end
            if (state_q == SAVE && cause_q == CAUSE_W'(k)) begin
                clr_mask[k] = 1'b1;
            end
        end
        // set wins over clear on the same bit
        pending_d = (pending_q & ~clr_mask) | irq_rise;
    end

    // Next state and registered outputs, decoded from the next state.
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        epc_pc_d    = epc_pc_q;
        pc_target_d = pc_target_q;
        vector      = {bus.tvec_i[31:2], 2'b00};
        unique case (state_q)
            IDLE: begin
                if (bus.mret_i) begin
                    state_d = RET;
                end else if (pending_q != '0 && bus.mie_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.mret_i) begin
                    state_d = RET;
                end else if (pending_q == '0 || !bus.mie_i) begin
                    state_d = IDLE;
                end else if (bus.halt_ack_i) begin
                    state_d  = SAVE;
                    cause_d  = sel;
                    epc_pc_d = bus.pc_i;
                end
            end
            SAVE: state_d = TRAP;
            TRAP: begin
                if (bus.mret_i) begin
                    state_d = RET;
                end
            end
            RET:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
`ifdef IRQ_VECTORED_EN
        vector = {bus.tvec_i[31:2], 2'b00} + (32'(cause_d) << 2);
`endif
        if (state_d == SAVE) begin
            pc_target_d = vector;
        end else if (state_d == RET) begin
            pc_target_d = bus.epc_i;
        end
        halt_req_d = (state_d == REQ);
        save_epc_d = (state_d == SAVE);
        mret_d     = (state_d == RET);
        pc_set_d   = (state_d == SAVE) || (state_d == RET);
        in_trap_d  = (state_d == SAVE) || (state_d == TRAP);
    end

    // State and output registers; reset discards any partial trap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            irq_q       <= '0;
            armed_q     <= 1'b0;
            pending_q   <= '0;
            cause_q     <= '0;
            epc_pc_q    <= '0;
            pc_target_q <= '0;
            halt_req_q  <= 1'b0;
            save_epc_q  <= 1'b0;
            mret_q      <= 1'b0;
            pc_set_q    <= 1'b0;
            in_trap_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            irq_q       <= irq_d;
            armed_q     <= armed_d;
            pending_q   <= pending_d;
            cause_q     <= cause_d;
            epc_pc_q    <= epc_pc_d;
            pc_target_q <= pc_target_d;
            halt_req_q  <= halt_req_d;
            save_epc_q  <= save_epc_d;
            mret_q      <= mret_d;
            pc_set_q    <= pc_set_d;
            in_trap_q   <= in_trap_d;
        end
    end

    assign bus.halt_req_o  = halt_req_q;
    assign bus.save_epc_o  = save_epc_q;
    assign bus.epc_pc_o    = epc_pc_q;
    assign bus.mret_o      = mret_q;
    assign bus.pc_set_o    = pc_set_q;
    assign bus.pc_target_o = pc_target_q;
    assign bus.cause_o     = cause_q;
    assign bus.in_trap_o   = in_trap_q;
endmodule

// File: tb/tb_irq_trap_ctrl.sv
// Scoreboard bench for irq_trap_ctrl: stimulus pushes expected CSR strobe
// records; a negedge monitor pops and compares on every save/mret strobe.
module tb_irq_trap_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] irq_i = '0;

    irq_trap_ctrl_if #(.CAUSE_W(4)) bus ();

    irq_trap_ctrl #(.N_IRQ(8), .CAUSE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .irq_i (irq_i),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_ret;
        logic [31:0] epc;
        logic [31:0] target;
        logic [3:0]  cause;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] exp_vec(input logic [31:0] tvec, input logic [3:0] c);
        logic [31:0] b;
        b = {tvec[31:2], 2'b00};
`ifdef IRQ_VECTORED_EN
        return b + ({28'd0, c} << 2);
`else
        return b;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_halt(input string name);
        int n = 0;
        while (!bus.halt_req_o && n < 20) begin
            tick();
            n++;
        end
        chk(name, 64'(bus.halt_req_o), 64'd1);
    endtask

    task automatic service(input logic [3:0] c, input logic [31:0] pc, input logic [31:0] tvec);
        bus.tvec_i = tvec;
        bus.pc_i   = pc;
        exp_q.push_back('{1'b0, pc, exp_vec(tvec, c), c});
        bus.halt_ack_i = 1'b1;
        tick();
        bus.halt_ack_i = 1'b0;
        tick();
        chk("trap_in_trap", 64'(bus.in_trap_o), 64'd1);
    endtask

    task automatic do_mret(input logic [31:0] epc, input logic [3:0] c);
        bus.epc_i  = epc;
        bus.mret_i = 1'b1;
        exp_q.push_back('{1'b1, 32'd0, epc, c});
        tick();
        bus.mret_i = 1'b0;
        tick();
        chk("idle_after_ret", {62'd0, bus.in_trap_o, bus.pc_set_o}, 64'd0);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_strobes"}, {55'd0, bus.halt_req_o, bus.save_epc_o, bus.mret_o,
             bus.pc_set_o, bus.in_trap_o, bus.cause_o}, 64'd0);
        chk({name, "_pcs"}, {bus.epc_pc_o, bus.pc_target_o}, 64'd0);
    endtask

    // Monitor: every CSR strobe must match the oldest expected record.
    always @(negedge clk) begin
        if (rst_n && (bus.save_epc_o || bus.mret_o)) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_strobe actual save=%0b mret=%0b required none",
                         bus.save_epc_o, bus.mret_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_kind", {62'd0, bus.save_epc_o, bus.mret_o},
                    e.is_ret ? 64'd1 : 64'd2);
                chk("pc_target", 64'(bus.pc_target_o), 64'(e.target));
                chk("pc_set", 64'(bus.pc_set_o), 64'd1);
                chk("cause", 64'(bus.cause_o), 64'(e.cause));
                chk("halt_req_low", 64'(bus.halt_req_o), 64'd0);
                if (!e.is_ret) begin
                    chk("epc_pc", 64'(bus.epc_pc_o), 64'(e.epc));
                    chk("save_in_trap", 64'(bus.in_trap_o), 64'd1);
                end else begin
                    chk("ret_in_trap", 64'(bus.in_trap_o), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bus.mie_i = 1'b1; bus.tvec_i = '0; bus.epc_i = '0; bus.pc_i = '0;
        bus.mret_i = 1'b0; bus.halt_ack_i = 1'b0;
        repeat (3) tick();
        chk_reset("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: single IRQ, latency and save contents
        irq_i = 8'h08;
        tick();
        chk("t1_no_halt_t1", 64'(bus.halt_req_o), 64'd0);
        tick();
        chk("t1_halt_t2", 64'(bus.halt_req_o), 64'd1);
        service(4'd3, 32'h100, 32'h80);
        // 4: return from trap
        do_mret(32'h204, 4'd3);
        irq_i = 8'h00;
        tick();

        // 2: simultaneous IRQs, lowest index first; tvec low bits masked, vector wraps
        irq_i = 8'h22;
        wait_halt("t2_halt_a");
        service(4'd1, 32'h300, 32'hFFFF_FFF3);
        do_mret(32'h304, 4'd1);
        wait_halt("t2_halt_b");
        service(4'd5, 32'h400, 32'hFFFF_FFF3);
        do_mret(32'h404, 4'd5);
        irq_i = 8'h00;
        tick();

        // 3: masked interrupts never request halt
        bus.mie_i = 1'b0;
        irq_i = 8'h04;
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen |= bus.halt_req_o;
        end
        chk("t3_mie0_no_halt", 64'(seen), 64'd0);
        bus.mie_i = 1'b1;
        wait_halt("t3_halt");
        service(4'd2, 32'h500, 32'h80);
        do_mret(32'h504, 4'd2);
        irq_i = 8'h00;
        tick();

        // 5: mret during REQ aborts, pending kept, REQ re-entered
        irq_i = 8'h10;
        wait_halt("t5_halt");
        bus.epc_i  = 32'h600;
        bus.mret_i = 1'b1;
        exp_q.push_back('{1'b1, 32'd0, 32'h600, 4'd2});
        tick();
        bus.mret_i = 1'b0;
        chk("t5_halt_dropped", 64'(bus.halt_req_o), 64'd0);
        wait_halt("t5_halt_again");
        service(4'd4, 32'h700, 32'h80);
        do_mret(32'h704, 4'd4);

        // 6: reset mid-REQ with a held-high line
        irq_i = 8'h50;
        wait_halt("t6_halt");
        rst_n = 1'b0;
        #1;
        chk_reset("t6_async_reset");
        tick();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen |= bus.halt_req_o | bus.save_epc_o;
        end
        chk("t6_no_retrigger", 64'(seen), 64'd0);
        chk_reset("t6_after_reset");
        irq_i = 8'h00;
        tick();
        irq_i = 8'h40;
        wait_halt("t6_new_edge_halt");
        service(4'd6, 32'h800, 32'h80);
        do_mret(32'h804, 4'd6);

        tick();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
